road_scroll: RTL and testbench

Per-frame road state generator sitting directly upstream of the road sprite renderer. It advances a sub-pixel vertical scroll offset and steers the road's horizontal position with an LFSR-driven curve. For every pixel it supplies the renderer's tile descriptor: sprite number, tile origin X, scroll offset Y and mirror flag. State changes only on a frame-start pulse, so descriptors stay stable for the whole visible frame.

---
 rtl/road_pkg.sv | 18 +
 rtl/road_lfsr.sv | 18 +
 rtl/road_scroll.sv | 111 +++++++++++
 tb/tb_road_scroll.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/road_pkg.sv
// Shared road types: renderer sprite codes, per-frame update FSM states, line width in tiles.
// No timing and no flow control here; only definitions imported by the road blocks.
package road_pkg;
  localparam int TILE_COLS = 20;

  localparam logic [1:0] SPR_EDGE  = 2'd0;
  localparam logic [1:0] SPR_LANE  = 2'd1;
  localparam logic [1:0] SPR_MARK  = 2'd2;
  localparam logic [1:0] SPR_GRASS = 2'd3;

  typedef enum logic [2:0] {
    ST_WAIT,
    ST_SCROLL,
    ST_LFSR,
    ST_CURVE,
    ST_DONE
  } state_t;
endpackage

// File: rtl/road_lfsr.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1); the new value is visible the cycle after step.
// No backpressure: it holds whenever step is low and reloads SEED on reset.
module road_lfsr #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       step,
  output logic [7:0] value
);
  always_ff @(posedge clk) begin
    if (rst) begin
      value <= SEED;
    end else if (step) begin
      value <= {value[6:0], value[7] ^ value[5] ^ value[4] ^ value[3]};
    end
  end
endmodule

// File: rtl/road_scroll.sv
// Per-frame road state: scroll accumulator, LFSR-steered left edge, zero-latency tile descriptor.
// A frame update takes 4 cycles; frame_start is dropped while busy or when enable is low.
module road_scroll
  import road_pkg::*;
#(
  parameter int         ROAD_W       = 8,
  parameter int         L_INIT       = 6,
  parameter int         L_MIN        = 0,
  parameter int         L_MAX        = 12,
  parameter int         CURVE_PERIOD = 16,
  parameter logic [7:0] LFSR_SEED    = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_start,
  input  logic       enable,
  input  logic [2:0] speed,
  input  logic [8:0] H_pos,
  input  logic [8:0] V_pos,
  output logic [1:0] sprite_number,
  output logic [8:0] X,
  output logic [4:0] Y,
  output logic       mirror,
  output logic       update_done
);
  localparam int CW = (CURVE_PERIOD > 1) ? $clog2(CURVE_PERIOD) : 1;

  state_t        state;
  logic [7:0]    acc;
  logic [7:0]    lfsr;
  logic [4:0]    left;
  logic [CW-1:0] frame_cnt;

  road_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .step  (state == ST_LFSR),
    .value (lfsr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_WAIT;
      acc         <= 8'd0;
      left        <= 5'(L_INIT);
      frame_cnt   <= '0;
      update_done <= 1'b0;
    end else begin
      update_done <= 1'b0;
      case (state)
        ST_WAIT: begin
          if (frame_start && enable) state <= ST_SCROLL;
        end
        ST_SCROLL: begin
          acc   <= acc + {5'd0, speed};
          state <= ST_LFSR;
        end
        ST_LFSR: begin
          state <= ST_CURVE;
        end
        ST_CURVE: begin
          // lfsr was stepped in the previous state, so the decision uses the fresh value
          if (frame_cnt == CW'(CURVE_PERIOD - 1)) begin
            frame_cnt <= '0;
            case (lfsr[1:0])
              2'b00: if (left != 5'(L_MIN)) left <= left - 5'd1;
              2'b01: if (left != 5'(L_MAX)) left <= left + 5'd1;
              default: ;
            endcase
          end else begin
            frame_cnt <= frame_cnt + 1'b1;
          end
          update_done <= 1'b1;
          state       <= ST_DONE;
        end
        ST_DONE: begin
          state <= ST_WAIT;
        end
        default: state <= ST_WAIT;
      endcase
    end
  end

  // 6-bit column arithmetic so right-edge/centre positions never wrap
  logic [5:0] col, left_col, right_col, mark_col;
  assign col       = {1'b0, H_pos[8:4]};
  assign left_col  = {1'b0, left};
  assign right_col = left_col + 6'(ROAD_W - 1);
  assign mark_col  = left_col + 6'(ROAD_W / 2);

  always_comb begin
    sprite_number = SPR_GRASS;
    mirror        = H_pos[4] ^ lfsr[0];
    if (col == left_col) begin
      sprite_number = SPR_EDGE;
      mirror        = 1'b0;
    end else if (col == right_col) begin
      sprite_number = SPR_EDGE;
      mirror        = 1'b1;
    end else if (col > left_col && col < right_col) begin
      sprite_number = (col == mark_col) ? SPR_MARK : SPR_LANE;
      mirror        = 1'b0;
    end
  end

  assign X = {H_pos[8:4], 4'b0000};
  assign Y = acc[7:3];

  logic inputs_unused;
  assign inputs_unused = ^{V_pos, H_pos[3:0], lfsr[7:2]};
endmodule

// File: tb/tb_road_scroll.sv
// Directed bench for road_scroll: descriptor table at reset, frame timing, wrap, enable, clamp, mid-update reset.
module tb_road_scroll;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_start = 1'b0;
  logic       enable = 1'b0;
  logic       enable_b = 1'b0;
  logic [2:0] speed = 3'd0;
  logic [8:0] H_pos = 9'd0;
  logic [8:0] V_pos = 9'd0;

  logic [1:0] spr0, spr1, spr2;
  logic [8:0] x0, x1, x2;
  logic [4:0] y0, y1, y2;
  logic       mir0, mir1, mir2;
  logic       done0, done1, done2;

  int tests = 0;
  int fails = 0;
  int mon_sel = 0;

  int         m_acc;
  logic [7:0] m_lfsr [3];
  int         m_left [3];
  int         m_cnt  [3];
  int         period [3] = '{16, 1, 1};
  int         l_init [3] = '{6, 0, 12};
  logic [7:0] seed   [3] = '{8'hA5, 8'h02, 8'h08};

  typedef struct {
    int h;
    int spr;
    int mir;
  } vec_t;
  vec_t tbl [16];

  always #5 clk = ~clk;

  road_scroll u_main (
    .clk(clk), .rst(rst), .frame_start(frame_start), .enable(enable), .speed(speed),
    .H_pos(H_pos), .V_pos(V_pos), .sprite_number(spr0), .X(x0), .Y(y0),
    .mirror(mir0), .update_done(done0));

  road_scroll #(.L_INIT(0), .CURVE_PERIOD(1), .LFSR_SEED(8'h02)) u_lo (
    .clk(clk), .rst(rst), .frame_start(frame_start), .enable(enable_b), .speed(speed),
    .H_pos(H_pos), .V_pos(V_pos), .sprite_number(spr1), .X(x1), .Y(y1),
    .mirror(mir1), .update_done(done1));

  road_scroll #(.L_INIT(12), .CURVE_PERIOD(1), .LFSR_SEED(8'h08)) u_hi (
    .clk(clk), .rst(rst), .frame_start(frame_start), .enable(enable_b), .speed(speed),
    .H_pos(H_pos), .V_pos(V_pos), .sprite_number(spr2), .X(x2), .Y(y2),
    .mirror(mir2), .update_done(done2));

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] lstep(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  task automatic model_reset();
    m_acc = 0;
    for (int i = 0; i < 3; i++) begin
      m_lfsr[i] = seed[i];
      m_left[i] = l_init[i];
      m_cnt[i]  = 0;
    end
  endtask

  task automatic model_curve(input int i);
    m_lfsr[i] = lstep(m_lfsr[i]);
    if (m_cnt[i] == period[i] - 1) begin
      m_cnt[i] = 0;
      if (m_lfsr[i][1:0] == 2'b00 && m_left[i] > 0) m_left[i]--;
      else if (m_lfsr[i][1:0] == 2'b01 && m_left[i] < 12) m_left[i]++;
    end else begin
      m_cnt[i]++;
    end
  endtask

  function automatic int sel_spr(input int i);
    return (i == 0) ? int'(spr0) : (i == 1) ? int'(spr1) : int'(spr2);
  endfunction

  function automatic int sel_mir(input int i);
    return (i == 0) ? int'(mir0) : (i == 1) ? int'(mir1) : int'(mir2);
  endfunction

  task automatic find_left(input int i, output int l);
    l = -1;
    for (int c = 0; c < 20; c++) begin
      H_pos = 9'(c * 16);
      #1;
      if (sel_spr(i) == 0 && sel_mir(i) == 0 && l < 0) l = c;
    end
  endtask

  // One frame pulse; checks Y before/after t+2 and that update_done appears only at t+4.
  task automatic do_frame(input logic [2:0] sp, input bit exp_done);
    int hits, first, old_y, new_y;
    bit dn;
    old_y = m_acc >> 3;
    if (enable) begin
      m_acc = (m_acc + int'(sp)) % 256;
      model_curve(0);
    end
    if (enable_b) begin
      model_curve(1);
      model_curve(2);
    end
    new_y = m_acc >> 3;
    hits = 0;
    first = 0;
    @(negedge clk);
    speed = sp;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      if (k > 1) @(negedge clk);
      if (k == 1) chk("y_before_update", int'(y0), old_y);
      if (k == 2) chk("y_at_t_plus_2", int'(y0), new_y);
      dn = (mon_sel == 0) ? done0 : done1;
      if (dn) begin
        hits++;
        if (first == 0) first = k;
      end
    end
    chk("update_done_count", hits, exp_done ? 1 : 0);
    if (exp_done) chk("update_done_cycle", first, 4);
  endtask

  initial begin
    int l, exp_spr, exp_mir, c, got_l1, got_l2;

    tbl[0]  = '{0,   3, 1};
    tbl[1]  = '{15,  3, 1};
    tbl[2]  = '{16,  3, 0};
    tbl[3]  = '{95,  3, 0};
    tbl[4]  = '{96,  0, 0};
    tbl[5]  = '{111, 0, 0};
    tbl[6]  = '{112, 1, 0};
    tbl[7]  = '{150, 1, 0};
    tbl[8]  = '{160, 2, 0};
    tbl[9]  = '{176, 1, 0};
    tbl[10] = '{207, 1, 0};
    tbl[11] = '{208, 0, 1};
    tbl[12] = '{224, 3, 1};
    tbl[13] = '{239, 3, 1};
    tbl[14] = '{240, 3, 0};
    tbl[15] = '{319, 3, 0};

    model_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // reset state: L=6, lfsr=A5, acc=0
    H_pos = 9'd0;
    #1;
    chk("reset_y", int'(y0), 0);
    chk("reset_update_done", int'(done0), 0);
    chk("reset_h0_sprite", int'(spr0), 3);
    chk("reset_h0_mirror", int'(mir0), 1);

    foreach (tbl[i]) begin
      H_pos = 9'(tbl[i].h);
      #1;
      chk("table_sprite", int'(spr0), tbl[i].spr);
      chk("table_mirror", int'(mir0), tbl[i].mir);
      chk("table_x", int'(x0), tbl[i].h & ~15);
    end

    for (int h = 0; h < 320; h++) begin
      H_pos = 9'(h);
      #1;
      c = h / 16;
      if (c < 6 || c > 13) begin exp_spr = 3; exp_mir = (c & 1) ^ 1; end
      else if (c == 6) begin exp_spr = 0; exp_mir = 0; end
      else if (c == 13) begin exp_spr = 0; exp_mir = 1; end
      else if (c == 10) begin exp_spr = 2; exp_mir = 0; end
      else begin exp_spr = 1; exp_mir = 0; end
      chk("sweep_descriptor", int'(spr0) * 1024 + int'(mir0) * 512 + int'(x0),
          exp_spr * 1024 + exp_mir * 512 + (c * 16));
    end

    // ten frames at speed 5
    enable = 1'b1;
    for (int f = 0; f < 10; f++) do_frame(3'd5, 1'b1);
    chk("acc50_y", int'(y0), 6);
    find_left(0, l);
    chk("left_after_10", l, m_left[0]);

    // disabled: frame pulses ignored entirely
    enable = 1'b0;
    for (int f = 0; f < 5; f++) do_frame(3'd5, 1'b0);
    chk("disabled_y", int'(y0), 6);
    find_left(0, l);
    chk("disabled_left", l, 6);
    H_pos = 9'd0;
    #1;
    chk("disabled_lfsr_bit0", int'(mir0), int'(m_lfsr[0][0]));

    // climb to acc=254 then wrap with +3
    enable = 1'b1;
    for (int f = 0; f < 29; f++) do_frame(3'd7, 1'b1);
    do_frame(3'd1, 1'b1);
    chk("acc254_y", int'(y0), 31);
    do_frame(3'd3, 1'b1);
    chk("wrap_y", int'(y0), 0);
    chk("wrap_model_acc", m_acc, 1);
    find_left(0, l);
    chk("left_after_decisions", l, m_left[0]);
    H_pos = 9'd0;
    #1;
    chk("lfsr_bit0_after_41", int'(mir0), int'(m_lfsr[0][0]));

    // reset in the middle of an update
    do_frame(3'd7, 1'b1);
    chk("acc8_y", int'(y0), 1);
    @(negedge clk);
    speed = 3'd7;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    @(negedge clk);
    chk("midupd_y_t2", int'(y0), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk("midupd_reset_y", int'(y0), 0);
    chk("midupd_reset_done", int'(done0), 0);
    l = 0;
    for (int k = 0; k < 6; k++) begin
      if (done0) l++;
      @(negedge clk);
    end
    chk("midupd_no_done", l, 0);
    find_left(0, l);
    chk("midupd_left", l, 6);
    H_pos = 9'd0;
    #1;
    chk("midupd_lfsr_seed_bit0", int'(mir0), 1);
    do_frame(3'd2, 1'b1);

    // clamp at both bounds with a decision every frame
    enable = 1'b0;
    enable_b = 1'b1;
    mon_sel = 1;
    do_frame(3'd0, 1'b1);
    find_left(1, got_l1);
    find_left(2, got_l2);
    chk("clamp_lo_first", got_l1, 0);
    chk("clamp_hi_first", got_l2, 12);
    for (int f = 1; f < 16; f++) begin
      do_frame(3'd0, 1'b1);
      find_left(1, got_l1);
      find_left(2, got_l2);
      chk("clamp_lo_track", got_l1, m_left[1]);
      chk("clamp_hi_track", got_l2, m_left[2]);
    end
    enable_b = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
